// File: rtl/param_sync_fifo_if.sv
// ---------------------------------------------------------------------------
// param_sync_fifo_if
//   Handshake/data bundle for param_sync_fifo.
//   master : producer/consumer side (drives clear, writeEn, dataIn, readEn)
//   slave  : FIFO side (drives dataOut, dataValid, status flags, count,
//            sticky overflow/underflow)
// ---------------------------------------------------------------------------
interface param_sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  clear;
    logic                  writeEn;
    logic [DATA_WIDTH-1:0] dataIn;
    logic                  readEn;
    logic [DATA_WIDTH-1:0] dataOut;
    logic                  dataValid;
    logic                  Full;
    logic                  Empty;
    logic                  almostFull;
    logic                  almostEmpty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clear, writeEn, dataIn, readEn,
        input  dataOut, dataValid, Full, Empty, almostFull, almostEmpty,
               count, overflow, underflow
    );

    modport slave (
        input  clear, writeEn, dataIn, readEn,
        output dataOut, dataValid, Full, Empty, almostFull, almostEmpty,
               count, overflow, underflow
    );
endinterface

// File: rtl/param_sync_fifo.sv
// ---------------------------------------------------------------------------
// param_sync_fifo
//   Single-clock FIFO, DEPTH = 2**ADDR_WIDTH words of DATA_WIDTH bits.
//   Concurrent read+write, registered read data with a one-cycle valid
//   pulse, occupancy count, programmable almost-full/almost-empty levels,
//   synchronous flush and sticky overflow/underflow flags.
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   bus    : param_sync_fifo_if.slave
//            clear/writeEn/dataIn/readEn in;
//            dataOut/dataValid/Full/Empty/almostFull/almostEmpty/
//            count/overflow/underflow out
// ---------------------------------------------------------------------------
module param_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic              clk,
    input  logic              reset,
    param_sync_fifo_if.slave  bus
);
    localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);

    // Storage is deliberately left out of reset.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic [DATA_WIDTH-1:0] dout_q,   dout_d;
    logic                  dvalid_q, dvalid_d;
    logic                  ovf_q,    ovf_d;
    logic                  unf_q,    unf_d;

    logic full, empty;
    logic wr_ok, rd_ok;
    logic mem_we;

    // Status flags depend only on the registered count, so there is no
    // combinational path from the request inputs to any output.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // A full FIFO still takes a write when a read frees a slot on the same
    // edge. An empty FIFO never serves a read on the write's edge: the new
    // word is only visible from the next cycle.
    assign wr_ok  = bus.writeEn & (~full | bus.readEn);
    assign rd_ok  = bus.readEn & ~empty;
    assign mem_we = wr_ok & ~bus.clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (bus.clear) begin
            // Flush wins over any request in the same cycle; dataOut holds.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                dout_d   = mem_q[rd_ptr_q];
                dvalid_d = 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            // A write to a full FIFO with a read alongside is accepted, so
            // only the read-less case is an overflow.
            if (bus.writeEn & full & ~bus.readEn) begin
                ovf_d = 1'b1;
            end
            if (bus.readEn & empty) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= bus.dataIn;
        end
    end

    assign bus.dataOut     = dout_q;
    assign bus.dataValid   = dvalid_q;
    assign bus.Full        = full;
    assign bus.Empty       = empty;
    assign bus.almostFull  = (count_q >= AF_C);
    assign bus.almostEmpty = (count_q <= AE_C);
    assign bus.count       = count_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AFL   = 6;
    localparam int AEL   = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    param_sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    param_sync_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: mq holds FIFO contents, exp_q holds read data that
    // is owed to the output and is consumed when the DUT flags dataValid.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_dout;
    logic          m_dv, m_ovf, m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_dout = '0;
        m_dv   = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic check_state(input string ph);
        int n;
        n = mq.size();
        if (bus.dataValid === 1'b1) begin
            if (exp_q.size() == 0) check({ph, ".spurious_valid"}, 32'd1, 32'd0);
            else                   check({ph, ".rd_data"}, 32'(bus.dataOut), 32'(exp_q.pop_front()));
        end
        check({ph, ".dataValid"},   32'(bus.dataValid),   32'(m_dv));
        check({ph, ".dataOut"},     32'(bus.dataOut),     32'(m_dout));
        check({ph, ".count"},       32'(bus.count),       32'(n));
        check({ph, ".Full"},        32'(bus.Full),        32'(n == DEPTH));
        check({ph, ".Empty"},       32'(bus.Empty),       32'(n == 0));
        check({ph, ".almostFull"},  32'(bus.almostFull),  32'(n >= AFL));
        check({ph, ".almostEmpty"}, 32'(bus.almostEmpty), 32'(n <= AEL));
        check({ph, ".overflow"},    32'(bus.overflow),    32'(m_ovf));
        check({ph, ".underflow"},   32'(bus.underflow),   32'(m_unf));
    endtask

    // One clock: drive at negedge, advance the model on pre-edge state,
    // compare just after the rising edge.
    task automatic cyc(input logic we, input logic [DW-1:0] d, input logic re,
                       input logic clr, input string ph);
        bit full, empty, rok, wok;
        @(negedge clk);
        bus.writeEn = we;
        bus.dataIn  = d;
        bus.readEn  = re;
        bus.clear   = clr;
        if (!reset) begin
            model_reset();
        end else if (clr) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_dv  = 1'b0;
        end else begin
            full  = (mq.size() == DEPTH);
            empty = (mq.size() == 0);
            rok   = re && !empty;
            wok   = we && (!full || re);
            if (we && full && !re) m_ovf = 1'b1;
            if (re && empty)       m_unf = 1'b1;
            if (rok) begin
                m_dout = mq.pop_front();
                exp_q.push_back(m_dout);
            end
            if (wok) mq.push_back(d);
            m_dv = rok;
        end
        @(posedge clk);
        #1;
        check_state(ph);
    endtask

    task automatic idle(input string ph);
        cyc(1'b0, '0, 1'b0, 1'b0, ph);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.writeEn = 1'b0;
        bus.dataIn  = '0;
        bus.readEn  = 1'b0;
        bus.clear   = 1'b0;
        model_reset();

        // 1: reset held with random inputs
        repeat (4) cyc(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), "reset");
        reset = 1'b1;
        idle("post_reset");

        // 2: fill / drain
        for (int i = 1; i <= DEPTH; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0, "fill");
        for (int i = 0; i < DEPTH; i++)  cyc(1'b0, '0, 1'b1, 1'b0, "drain");
        idle("drain_idle");

        // 3: pointer wrap
        for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'hF0 + i), 1'b0, 1'b0, "wrap_w5");
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0, "wrap_r5");
        for (int i = 0; i < 8; i++) cyc(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0, "wrap_w8");
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0, "wrap_r8");
        idle("wrap_idle");

        // 4: simultaneous read+write at full and at empty
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(8'h10 + i), 1'b0, 1'b0, "sim_fill");
        cyc(1'b1, 8'h55, 1'b1, 1'b0, "sim_full");
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0, "sim_drain");
        check("sim.last_is_55", 32'(bus.dataOut), 32'h55);
        idle("sim_idle");
        cyc(1'b1, 8'h66, 1'b1, 1'b0, "sim_empty");
        check("sim_empty.underflow", 32'(bus.underflow), 32'd1);
        check("sim_empty.count",     32'(bus.count),     32'd1);
        cyc(1'b0, '0, 1'b0, 1'b1, "sim_clear");

        // 5: error flags and clear
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(8'h20 + i), 1'b0, 1'b0, "err_fill");
        cyc(1'b1, 8'hEE, 1'b0, 1'b0, "err_ovf");
        check("err_ovf.overflow", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0, "err_drain");
        cyc(1'b0, '0, 1'b1, 1'b0, "err_unf");
        check("err_unf.dataOut_hold", 32'(bus.dataOut), 32'h27);
        cyc(1'b1, 8'h77, 1'b1, 1'b1, "err_clear");
        check("err_clear.overflow", 32'(bus.overflow), 32'd0);
        idle("err_idle");

        // 6: asynchronous reset mid-stream with a read in flight
        for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'h40 + i), 1'b0, 1'b0, "ar_fill");
        cyc(1'b0, '0, 1'b1, 1'b0, "ar_read");
        #3;
        reset = 1'b0;
        #1;
        check("ar.Empty",     32'(bus.Empty),     32'd1);
        check("ar.count",     32'(bus.count),     32'd0);
        check("ar.dataValid", 32'(bus.dataValid), 32'd0);
        check("ar.dataOut",   32'(bus.dataOut),   32'd0);
        model_reset();
        cyc(1'b1, 8'h99, 1'b1, 1'b0, "ar_hold");
        reset = 1'b1;
        cyc(1'b1, 8'h33, 1'b0, 1'b0, "ar_w33");
        cyc(1'b0, '0, 1'b1, 1'b0, "ar_r33");
        check("ar.readback_33", 32'(bus.dataOut), 32'h33);
        idle("ar_idle");

        // Random traffic with occasional flushes
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 99) < 55), DW'($urandom), 1'($urandom_range(0, 99) < 45),
                1'($urandom_range(0, 99) < 3), "rand");
        end
        idle("final");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
